gshare_recovery_ctrl: RTL and testbench
=======================================

GSHARE_RECOVERY_CTRL -- requirements
Module: gshare_recovery_ctrl

Interface
REQ-001 Parameter BH_SIZE, default 8, history/index width; SHALL equal the predictor's BH_SIZE.
REQ-002 Parameter QDEPTH, default 4, mispredict queue entries, power of two, >=2.
REQ-003 Parameter CNT_W, default 16, width of each event counter.
REQ-004 clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 fetch_req  in  1  fetch has a branch needing a prediction this cycle.
REQ-007 fetch_pc  in  32  PC of that branch.
REQ-008 rt_valid  in  1  a branch retires this cycle.
REQ-009 rt_mispredict  in  1  the retiring branch was mispredicted; qualified by rt_valid.
REQ-010 rt_pc_in  in  32  PC of the retiring branch.
REQ-011 rt_gh  in  BH_SIZE  history snapshot checkpointed with the retiring branch.
REQ-012 fetch_grant  out  1  prediction lookup issued to the predictor this cycle.
REQ-013 gs_enable, gs_if_branch  out  1 each  predictor lookup controls.
REQ-014 gs_pc_in  out  32  predictor lookup PC.
REQ-015 gs_clear_en, gs_obq_bh_pred_valid  out  1 each  predictor rollback/flip controls.
REQ-016 gs_obq_gh_in  out  BH_SIZE  rollback history.
REQ-017 gs_rt_pc  out  32  rollback PC.
REQ-018 busy  out  1  queue non-empty or FSM not IDLE.
REQ-019 overflow  out  1  sticky flag: a mispredict was dropped.
REQ-020 correct_cnt, mispred_cnt  out  CNT_W each  retirement event counters.

Function
REQ-021 Enqueue: rt_valid & rt_mispredict SHALL push {rt_pc_in, rt_gh} into a FIFO of QDEPTH entries.
REQ-022 Full FIFO with no same-cycle pop: push SHALL be dropped and overflow set; if a pop occurs in the same cycle, the push SHALL succeed.
REQ-023 FSM states: IDLE, RECOVER, SETTLE.
REQ-024 IDLE and FIFO non-empty: SHALL pop the head into recovery registers and go to RECOVER next cycle; otherwise stay in IDLE.
REQ-025 RECOVER, exactly 1 cycle:
- gs_clear_en=1 and gs_obq_bh_pred_valid=1.
- gs_obq_gh_in and gs_rt_pc driven from the recovery registers.
- Next state SETTLE.
REQ-026 SETTLE, exactly 1 cycle, all gs_* outputs 0; next state IDLE.
REQ-027 A new pop SHALL occur only in IDLE, so back-to-back recoveries are spaced 3 cycles apart (IDLE, RECOVER, SETTLE).
REQ-028 Lookup in IDLE: fetch_grant = fetch_req; gs_enable = gs_if_branch = fetch_grant; gs_pc_in = fetch_pc. This holds also in a cycle that pops.
REQ-029 Lookup in RECOVER and SETTLE: fetch_grant SHALL be 0; the requester holds the request.
REQ-030 When not driven, gs_clear_en, gs_obq_bh_pred_valid, gs_enable and gs_if_branch SHALL be 0; gs_pc_in, gs_rt_pc and gs_obq_gh_in SHALL be 0.
REQ-031 correct_cnt SHALL increment on rt_valid & !rt_mispredict.
REQ-032 mispred_cnt SHALL increment on rt_valid & rt_mispredict, including dropped pushes.
REQ-033 Both counters SHALL saturate at 2**CNT_W-1.
REQ-034 FIFO pointers SHALL wrap modulo QDEPTH; full and empty SHALL be distinguished by an occupancy count of width log2(QDEPTH)+1.
REQ-035 busy SHALL be combinational from occupancy and state.
REQ-036 No combinational path from gs_* predictor outputs; the block reads none.

Reset
REQ-037 On reset:
- FSM goes to IDLE; FIFO empties; recovery registers, counters and overflow clear.
- Reset mid-RECOVER or mid-SETTLE aborts the sequence; gs_clear_en SHALL be 0 in the cycle after reset is sampled.
REQ-038 With reset asserted, pushes and counter increments SHALL be ignored; all outputs read 0 except fetch_grant, which follows REQ-028 in IDLE.

Verification
REQ-039 Single mispredict, pc=0x40, gh=0x5A, while idle:
- next cycle is IDLE with the pop; the cycle after is RECOVER with gs_clear_en=1, gs_obq_gh_in=0x5A, gs_rt_pc=0x40;
- then SETTLE; fetch_grant=0 for exactly those 2 cycles; mispred_cnt=1.
REQ-040 Mispredicts on 5 consecutive cycles, QDEPTH=4:
- the first pops while the rest queue; all 5 are accepted, overflow=0;
- 5 RECOVER pulses spaced 3 cycles apart.
REQ-041 Mispredicts every cycle with a stalled drain: push while full with no pop gives overflow=1, and that entry never appears on gs_obq_gh_in; a push with a same-cycle pop is retained.
REQ-042 fetch_req held high throughout a recovery: grant pattern 1,0,0,1 across IDLE(pop), RECOVER, SETTLE, IDLE; gs_pc_in=fetch_pc whenever granted.
REQ-043 Reset asserted during RECOVER with 2 entries queued: the next cycle shows state IDLE, busy=0, gs_clear_en=0, counters=0, overflow=0.
REQ-044 CNT_W=4 with 20 correct retirements: correct_cnt saturates at 15; mispred_cnt stays 0.

Source files
------------

// File: rtl/gshare_recovery_ctrl.sv
// Mispredict recovery sequencer for a gshare predictor: queues retired mispredicts,
// replays each as a one-cycle rollback pulse, and arbitrates fetch lookups around it.
module gshare_recovery_ctrl #(
  parameter int BH_SIZE = 8,
  parameter int QDEPTH  = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               fetch_req,
  input  logic [31:0]        fetch_pc,
  input  logic               rt_valid,
  input  logic               rt_mispredict,
  input  logic [31:0]        rt_pc_in,
  input  logic [BH_SIZE-1:0] rt_gh,
  output logic               fetch_grant,
  output logic               gs_enable,
  output logic               gs_if_branch,
  output logic [31:0]        gs_pc_in,
  output logic               gs_clear_en,
  output logic               gs_obq_bh_pred_valid,
  output logic [BH_SIZE-1:0] gs_obq_gh_in,
  output logic [31:0]        gs_rt_pc,
  output logic               busy,
  output logic               overflow,
  output logic [CNT_W-1:0]   correct_cnt,
  output logic [CNT_W-1:0]   mispred_cnt
);

  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW:0]      DEPTH   = (AW+1)'(QDEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, RECOVER, SETTLE} state_t;

  state_t             state_q, state_d;
  logic [31:0]        mem_pc [QDEPTH];
  logic [BH_SIZE-1:0] mem_gh [QDEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        count_q;
  logic [31:0]        rec_pc_q;
  logic [BH_SIZE-1:0] rec_gh_q;
  logic               overflow_q;
  logic [CNT_W-1:0]   correct_q, mispred_q;

  logic push_req, empty, full, pop, push, drop;

  assign push_req = rt_valid & rt_mispredict;
  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH);
  assign pop      = (state_q == IDLE) && !empty;
  // A pop in the same cycle frees the slot, so a push into a full queue still lands.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rec_pc_q   <= '0;
      rec_gh_q   <= '0;
      overflow_q <= 1'b0;
      correct_q  <= '0;
      mispred_q  <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        rec_pc_q <= mem_pc[rd_ptr_q];
        rec_gh_q <= mem_gh[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop) overflow_q <= 1'b1;
      if (rt_valid && !rt_mispredict && correct_q != CNT_MAX) correct_q <= correct_q + 1'b1;
      if (push_req && mispred_q != CNT_MAX) mispred_q <= mispred_q + 1'b1;
    end
  end

  // NOTE: queue storage has no reset; occupancy and pointers alone define which
  // entries are valid, so clearing the array would only add reset fan-out.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem_pc[wr_ptr_q] <= rt_pc_in;
      mem_gh[wr_ptr_q] <= rt_gh;
    end
  end

  // NOTE: every output and next-state variable gets a default first so no path
  // through the case leaves one unassigned and infers a latch.
  always_comb begin
    state_d              = state_q;
    fetch_grant          = 1'b0;
    gs_enable            = 1'b0;
    gs_if_branch         = 1'b0;
    gs_pc_in             = '0;
    gs_clear_en          = 1'b0;
    gs_obq_bh_pred_valid = 1'b0;
    gs_obq_gh_in         = '0;
    gs_rt_pc             = '0;
    case (state_q)
      IDLE: begin
        fetch_grant  = fetch_req;
        gs_enable    = fetch_req;
        gs_if_branch = fetch_req;
        gs_pc_in     = fetch_req ? fetch_pc : '0;
        if (pop) state_d = RECOVER;
      end
      RECOVER: begin
        gs_clear_en          = 1'b1;
        gs_obq_bh_pred_valid = 1'b1;
        gs_obq_gh_in         = rec_gh_q;
        gs_rt_pc             = rec_pc_q;
        state_d              = SETTLE;
      end
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // While reset is held, only the idle-state fetch grant stays live.
    if (reset) begin
      gs_enable            = 1'b0;
      gs_if_branch         = 1'b0;
      gs_pc_in             = '0;
      gs_clear_en          = 1'b0;
      gs_obq_bh_pred_valid = 1'b0;
      gs_obq_gh_in         = '0;
      gs_rt_pc             = '0;
    end
  end

  assign busy        = !reset && (!empty || state_q != IDLE);
  assign overflow    = !reset && overflow_q;
  assign correct_cnt = reset ? '0 : correct_q;
  assign mispred_cnt = reset ? '0 : mispred_q;

endmodule

// File: tb/tb_gshare_recovery_ctrl.sv
// Directed bench for gshare_recovery_ctrl: recovery timing, queueing/overflow,
// fetch arbitration, mid-sequence reset and counter saturation.
module tb_gshare_recovery_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        rt_valid = 1'b0;
  logic        rt_mispredict = 1'b0;
  logic [31:0] rt_pc_in = '0;
  logic [7:0]  rt_gh = '0;

  logic        fetch_grant, gs_enable, gs_if_branch, gs_clear_en, gs_obq_bh_pred_valid;
  logic [31:0] gs_pc_in, gs_rt_pc;
  logic [7:0]  gs_obq_gh_in;
  logic        busy, overflow;
  logic [15:0] correct_cnt, mispred_cnt;

  logic        s_fetch_grant, s_gs_enable, s_gs_if_branch, s_gs_clear_en, s_gs_valid;
  logic [31:0] s_gs_pc_in, s_gs_rt_pc;
  logic [7:0]  s_gs_gh;
  logic        s_busy, s_overflow;
  logic [3:0]  s_correct_cnt, s_mispred_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  bit dropped_seen;

  gshare_recovery_ctrl dut (
    .clock(clock), .reset(reset), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
    .rt_valid(rt_valid), .rt_mispredict(rt_mispredict), .rt_pc_in(rt_pc_in), .rt_gh(rt_gh),
    .fetch_grant(fetch_grant), .gs_enable(gs_enable), .gs_if_branch(gs_if_branch),
    .gs_pc_in(gs_pc_in), .gs_clear_en(gs_clear_en), .gs_obq_bh_pred_valid(gs_obq_bh_pred_valid),
    .gs_obq_gh_in(gs_obq_gh_in), .gs_rt_pc(gs_rt_pc), .busy(busy), .overflow(overflow),
    .correct_cnt(correct_cnt), .mispred_cnt(mispred_cnt)
  );

  gshare_recovery_ctrl #(.CNT_W(4)) dut_sat (
    .clock(clock), .reset(reset), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
    .rt_valid(rt_valid), .rt_mispredict(rt_mispredict), .rt_pc_in(rt_pc_in), .rt_gh(rt_gh),
    .fetch_grant(s_fetch_grant), .gs_enable(s_gs_enable), .gs_if_branch(s_gs_if_branch),
    .gs_pc_in(s_gs_pc_in), .gs_clear_en(s_gs_clear_en), .gs_obq_bh_pred_valid(s_gs_valid),
    .gs_obq_gh_in(s_gs_gh), .gs_rt_pc(s_gs_rt_pc), .busy(s_busy), .overflow(s_overflow),
    .correct_cnt(s_correct_cnt), .mispred_cnt(s_mispred_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic m, input logic [31:0] pc, input logic [7:0] gh);
    rt_valid      = v;
    rt_mispredict = m;
    rt_pc_in      = pc;
    rt_gh         = gh;
  endtask

  // Pushes n_push mispredicts on consecutive cycles from an idle, empty queue and
  // expects the rollbacks listed in exp_q on cycles 2, 5, 8, ...
  task automatic run_stream(input int n_push, input logic [7:0] base, input int n_cycles,
                            input logic [7:0] drop_gh);
    int k;
    k = 0;
    dropped_seen = 1'b0;
    for (int c = 0; c < n_cycles; c++) begin
      if (c < n_push) drive(1'b1, 1'b1, 32'h1000 + 32'(c * 4), base + 8'(c));
      else            drive(1'b0, 1'b0, '0, '0);
      #1;
      if (c >= 2 && (c - 2) % 3 == 0 && k < exp_q.size()) begin
        check($sformatf("rec%0d_clear", k), gs_clear_en, 1);
        check($sformatf("rec%0d_valid", k), gs_obq_bh_pred_valid, 1);
        check($sformatf("rec%0d_gh", k), gs_obq_gh_in, exp_q[k]);
        check($sformatf("rec%0d_pc", k), gs_rt_pc, 32'h1000 + 32'(4 * int'(exp_q[k] - base)));
        k++;
      end else begin
        check($sformatf("noclear_c%0d", c), gs_clear_en, 0);
      end
      if (gs_clear_en && gs_obq_gh_in == drop_gh) dropped_seen = 1'b1;
      tick();
    end
    check("rec_count", 64'(k), 64'(exp_q.size()));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset: grant follows fetch_req in IDLE, all else reads 0, pushes ignored.
    tick();
    fetch_req = 1'b1;
    fetch_pc  = 32'h200;
    drive(1'b1, 1'b1, 32'h80, 8'h33);
    #1;
    check("rst_grant", fetch_grant, 1);
    check("rst_gs_enable", gs_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_mispred", mispred_cnt, 0);
    tick();
    reset     = 1'b0;
    fetch_req = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    #1;
    check("post_rst_busy", busy, 0);
    check("post_rst_clear", gs_clear_en, 0);
    check("post_rst_overflow", overflow, 0);
    check("post_rst_mispred", mispred_cnt, 0);
    check("post_rst_correct", correct_cnt, 0);
    tick();

    // Single mispredict with fetch_req held: grant pattern 1,0,0,1.
    fetch_req = 1'b1;
    fetch_pc  = 32'h100;
    drive(1'b1, 1'b1, 32'h40, 8'h5A);
    #1;
    check("s_push_grant", fetch_grant, 1);
    check("s_push_pc", gs_pc_in, 32'h100);
    check("s_push_busy", busy, 0);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    fetch_pc = 32'h104;
    #1;
    check("s_pop_grant", fetch_grant, 1);
    check("s_pop_enable", gs_if_branch, 1);
    check("s_pop_pc", gs_pc_in, 32'h104);
    check("s_pop_clear", gs_clear_en, 0);
    check("s_pop_busy", busy, 1);
    check("s_mispred", mispred_cnt, 1);
    tick();
    #1;
    check("s_rec_clear", gs_clear_en, 1);
    check("s_rec_valid", gs_obq_bh_pred_valid, 1);
    check("s_rec_gh", gs_obq_gh_in, 8'h5A);
    check("s_rec_pc", gs_rt_pc, 32'h40);
    check("s_rec_grant", fetch_grant, 0);
    check("s_rec_enable", gs_enable, 0);
    check("s_rec_pcin", gs_pc_in, 0);
    tick();
    #1;
    check("s_set_clear", gs_clear_en, 0);
    check("s_set_gh", gs_obq_gh_in, 0);
    check("s_set_grant", fetch_grant, 0);
    check("s_set_busy", busy, 1);
    tick();
    #1;
    check("s_idle_grant", fetch_grant, 1);
    check("s_idle_pc", gs_pc_in, 32'h104);
    check("s_idle_busy", busy, 0);
    fetch_req = 1'b0;
    tick();

    // Five consecutive mispredicts: all accepted, recoveries every 3 cycles.
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_stream(5, 8'h01, 18, 8'hFF);
    check("burst_overflow", overflow, 0);
    check("burst_mispred", mispred_cnt, 6);
    check("burst_busy", busy, 0);

    // Mispredict every cycle: 0x16 arrives full with no pop and is dropped,
    // 0x17 arrives full alongside a pop and is kept.
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h17};
    run_stream(8, 8'h10, 23, 8'h16);
    check("ovf_flag", overflow, 1);
    check("ovf_dropped_absent", dropped_seen, 0);
    check("ovf_mispred", mispred_cnt, 14);
    check("ovf_busy", busy, 0);

    // Reset during RECOVER with two entries queued.
    for (int c = 0; c < 5; c++) begin
      if (c < 4) drive(1'b1, 1'b1, 32'h2000 + 32'(c * 4), 8'h20 + 8'(c));
      else       drive(1'b0, 1'b0, '0, '0);
      tick();
    end
    drive(1'b1, 1'b1, 32'h3000, 8'h77);
    fetch_req = 1'b1;
    #1;
    check("mid_rec_clear", gs_clear_en, 1);
    check("mid_rec_gh", gs_obq_gh_in, 8'h21);
    reset = 1'b1;
    #1;
    check("in_rst_clear", gs_clear_en, 0);
    check("in_rst_grant", fetch_grant, 0);
    check("in_rst_busy", busy, 0);
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    #1;
    check("abort_busy", busy, 0);
    check("abort_clear", gs_clear_en, 0);
    check("abort_grant", fetch_grant, 1);
    check("abort_mispred", mispred_cnt, 0);
    check("abort_correct", correct_cnt, 0);
    check("abort_overflow", overflow, 0);
    check("abort_sat_mispred", s_mispred_cnt, 0);
    tick();
    #1;
    check("abort_next_clear", gs_clear_en, 0);
    check("abort_next_busy", busy, 0);
    fetch_req = 1'b0;

    // Twenty correct retirements: 4-bit counter saturates, 16-bit does not.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 32'h4000, 8'h00);
      tick();
      if (i == 13) check("sat_at14", s_correct_cnt, 14);
    end
    drive(1'b0, 1'b0, '0, '0);
    #1;
    check("sat_correct", s_correct_cnt, 15);
    check("sat_mispred", s_mispred_cnt, 0);
    check("wide_correct", correct_cnt, 20);
    check("wide_mispred", mispred_cnt, 0);
    check("sat_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
